// File: rtl/ysyx_22050019_lsu.sv
// Load/store unit: turns one decoded memory access into a single valid/ready
// transaction on a 64-bit data port, with strobes, lane shifting and load extension.
module ysyx_22050019_lsu #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              ram_we,
  input  logic              ram_re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  input  logic [5:0]        mem_r_wdth,
  input  logic [2:0]        mem_w_wdth,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [63:0]       mem_req_wdata,
  output logic [7:0]        mem_req_wstrb,
  input  logic              mem_resp_valid,
  input  logic [63:0]       mem_resp_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t            r_state, w_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [63:0]       r_wdata;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_sgn;
  logic [31:0]       r_cnt;
  logic [63:0]       r_rdata;
  logic              r_err;

  logic [1:0]  w_size;
  logic        w_sgn, w_wbad, w_mis, w_accept, w_fault, w_tmo, w_act;
  logic [63:0] w_sh, w_ext;
  logic [7:0]  w_base;

  // Size code: 0 byte, 1 half, 2 word, 3 double; decoded from whichever width field applies
  always_comb begin
    w_size = 2'd3;
    w_sgn  = 1'b0;
    if (ram_we) begin
      w_wbad = (mem_w_wdth & (mem_w_wdth - 3'd1)) != 3'd0;
      if (mem_w_wdth[2])      w_size = 2'd0;
      else if (mem_w_wdth[1]) w_size = 2'd1;
      else if (mem_w_wdth[0]) w_size = 2'd2;
    end else begin
      w_wbad = ((mem_r_wdth & (mem_r_wdth - 6'd1)) != 6'd0) | mem_r_wdth[2];
      if (mem_r_wdth[3] | mem_r_wdth[0]) begin
        w_size = 2'd0;
        w_sgn  = mem_r_wdth[3];
      end else if (mem_r_wdth[4] | mem_r_wdth[1]) begin
        w_size = 2'd1;
        w_sgn  = mem_r_wdth[4];
      end else if (mem_r_wdth[5]) begin
        w_size = 2'd2;
        w_sgn  = 1'b1;
      end
    end
    case (w_size)
      2'd0:    w_mis = 1'b0;
      2'd1:    w_mis = addr[0];
      2'd2:    w_mis = |addr[1:0];
      default: w_mis = |addr[2:0];
    endcase
  end

  assign w_accept = req_valid & (ram_we | ram_re);
  assign w_fault  = (ram_we & ram_re) | w_wbad | w_mis;
  assign w_tmo    = (TIMEOUT != 0) && (r_cnt == 32'(TIMEOUT - 1));

  // Timeout wins in REQ; in WAIT an arriving response still completes normally
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_nxt = w_fault ? S_RESP : S_REQ;
      S_REQ: begin
        if (w_tmo)              w_nxt = S_RESP;
        else if (mem_req_ready) w_nxt = S_WAIT;
      end
      S_WAIT: if (mem_resp_valid || w_tmo) w_nxt = S_RESP;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  assign w_sh = mem_resp_rdata >> {r_addr[2:0], 3'b000};

  always_comb begin
    case (r_size)
      2'd0:    w_ext = r_sgn ? {{56{w_sh[7]}},  w_sh[7:0]}  : {56'd0, w_sh[7:0]};
      2'd1:    w_ext = r_sgn ? {{48{w_sh[15]}}, w_sh[15:0]} : {48'd0, w_sh[15:0]};
      2'd2:    w_ext = {{32{w_sh[31]}}, w_sh[31:0]};
      default: w_ext = w_sh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_size  <= '0;
      r_sgn   <= 1'b0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_addr  <= addr;
          r_wdata <= wdata;
          r_we    <= ram_we;
          r_size  <= w_size;
          r_sgn   <= w_sgn;
          r_cnt   <= '0;
          if (w_fault) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 32'd1;
          if (w_tmo) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 32'd1;
          if (mem_resp_valid) begin
            r_err   <= 1'b0;
            r_rdata <= r_we ? '0 : w_ext;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (r_size)
      2'd0:    w_base = 8'h01;
      2'd1:    w_base = 8'h03;
      2'd2:    w_base = 8'h0F;
      default: w_base = 8'hFF;
    endcase
  end

  assign w_act         = ~rst & (r_state == S_REQ);
  assign req_ready     = ~rst & (r_state == S_IDLE);
  assign resp_valid    = ~rst & (r_state == S_RESP);
  assign resp_rdata    = rst ? '0 : r_rdata;
  assign resp_err      = ~rst & r_err;
  assign mem_req_valid = w_act;
  assign mem_req_we    = w_act & r_we;
  assign mem_req_addr  = w_act ? {r_addr[ADDR_W-1:3], 3'b000} : '0;
  assign mem_req_wdata = w_act ? (r_wdata << {r_addr[2:0], 3'b000}) : '0;
  assign mem_req_wstrb = (w_act & r_we) ? (w_base << r_addr[2:0]) : '0;

endmodule

// File: tb/tb_ysyx_22050019_lsu.sv
// Directed bench for ysyx_22050019_lsu: a default-TIMEOUT instance plus a
// TIMEOUT=4 instance sharing the same stimulus.
module tb_ysyx_22050019_lsu;

  logic        clk = 1'b0;
  logic        rst, req_valid, ram_we, ram_re, mem_req_ready, mem_resp_valid;
  logic [63:0] addr, wdata, mem_resp_rdata;
  logic [5:0]  mem_r_wdth;
  logic [2:0]  mem_w_wdth;

  logic        req_ready, resp_valid, resp_err, mem_req_valid, mem_req_we;
  logic [63:0] resp_rdata, mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wstrb;

  logic        t_req_ready, t_resp_valid, t_resp_err, t_mem_req_valid, t_mem_req_we;
  logic [63:0] t_resp_rdata, t_mem_req_addr, t_mem_req_wdata;
  logic [7:0]  t_mem_req_wstrb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22050019_lsu #(.ADDR_W(64), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .ram_we(ram_we), .ram_re(ram_re), .addr(addr), .wdata(wdata),
    .mem_r_wdth(mem_r_wdth), .mem_w_wdth(mem_w_wdth),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  ysyx_22050019_lsu #(.ADDR_W(64), .TIMEOUT(4)) dut_t (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(t_req_ready),
    .ram_we(ram_we), .ram_re(ram_re), .addr(addr), .wdata(wdata),
    .mem_r_wdth(mem_r_wdth), .mem_w_wdth(mem_w_wdth),
    .resp_valid(t_resp_valid), .resp_rdata(t_resp_rdata), .resp_err(t_resp_err),
    .mem_req_valid(t_mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(t_mem_req_we), .mem_req_addr(t_mem_req_addr),
    .mem_req_wdata(t_mem_req_wdata), .mem_req_wstrb(t_mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle; returns one cycle after the accepting edge
  task automatic issue(input logic we, input logic re, input logic [5:0] rw,
                       input logic [2:0] ww, input logic [63:0] a, input logic [63:0] d);
    req_valid = 1'b1; ram_we = we; ram_re = re;
    mem_r_wdth = rw; mem_w_wdth = ww; addr = a; wdata = d;
    tick();
    req_valid = 1'b0; ram_we = 1'b0; ram_re = 1'b0;
  endtask

  // From REQ: handshake now, memory answers the next cycle; returns in RESP
  task automatic mem_cycle(input logic [63:0] data);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = data;
    tick();
    mem_resp_valid = 1'b0; mem_resp_rdata = '0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; ram_we = 1'b0; ram_re = 1'b0;
    addr = '0; wdata = '0; mem_r_wdth = '0; mem_w_wdth = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    tick();
    tick();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);

    // request with neither direction is ignored
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("noop_req_ready", 64'(req_ready), 64'd1);
    chk("noop_mem_req_valid", 64'(mem_req_valid), 64'd0);

    // 1: ld
    issue(1'b0, 1'b1, 6'b000000, 3'b000, 64'h80000008, 64'd0);
    chk("ld_mem_req_valid", 64'(mem_req_valid), 64'd1);
    chk("ld_req_ready_busy", 64'(req_ready), 64'd0);
    chk("ld_mem_req_addr", mem_req_addr, 64'h80000008);
    chk("ld_wstrb", 64'(mem_req_wstrb), 64'd0);
    chk("ld_we", 64'(mem_req_we), 64'd0);
    mem_cycle(64'h1122334455667788);
    chk("ld_resp_valid", 64'(resp_valid), 64'd1);
    chk("ld_rdata", resp_rdata, 64'h1122334455667788);
    chk("ld_err", 64'(resp_err), 64'd0);
    tick();
    chk("ld_resp_pulse", 64'(resp_valid), 64'd0);
    chk("ld_rdata_hold", resp_rdata, 64'h1122334455667788);
    chk("ld_idle_ready", 64'(req_ready), 64'd1);

    // 2: lb / lbu
    issue(1'b0, 1'b1, 6'b001000, 3'b000, 64'h80000003, 64'd0);
    chk("lb_mem_req_addr", mem_req_addr, 64'h80000000);
    mem_cycle(64'h0000000080000000);
    chk("lb_rdata", resp_rdata, 64'hFFFFFFFFFFFFFF80);
    tick();
    issue(1'b0, 1'b1, 6'b000001, 3'b000, 64'h80000003, 64'd0);
    mem_cycle(64'h0000000080000000);
    chk("lbu_rdata", resp_rdata, 64'h0000000000000080);
    tick();

    // lh at byte 6: 0xF00D sign-extended; lhu zero-extended
    issue(1'b0, 1'b1, 6'b010000, 3'b000, 64'h80000006, 64'd0);
    mem_cycle(64'hF00D000000000000);
    chk("lh_rdata", resp_rdata, 64'hFFFFFFFFFFFFF00D);
    tick();
    issue(1'b0, 1'b1, 6'b000010, 3'b000, 64'h80000006, 64'd0);
    mem_cycle(64'hF00D000000000000);
    chk("lhu_rdata", resp_rdata, 64'h000000000000F00D);
    tick();

    // 3: sh with mem_req_ready held low for three cycles
    issue(1'b1, 1'b0, 6'b000000, 3'b010, 64'h80000006, 64'h000000000000ABCD);
    for (int i = 0; i < 4; i++) begin
      chk("sh_valid", 64'(mem_req_valid), 64'd1);
      chk("sh_we", 64'(mem_req_we), 64'd1);
      chk("sh_addr", mem_req_addr, 64'h80000000);
      chk("sh_wstrb", 64'(mem_req_wstrb), 64'hC0);
      chk("sh_wdata", mem_req_wdata, 64'hABCD000000000000);
      if (i == 3) mem_req_ready = 1'b1;
      tick();
    end
    mem_req_ready = 1'b0;
    chk("sh_valid_dropped", 64'(mem_req_valid), 64'd0);
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    chk("sh_resp_valid", 64'(resp_valid), 64'd1);
    chk("sh_rdata", resp_rdata, 64'd0);
    chk("sh_err", 64'(resp_err), 64'd0);
    tick();

    // sb into the top byte lane
    issue(1'b1, 1'b0, 6'b000000, 3'b100, 64'h80000007, 64'h000000000000005A);
    chk("sb_wstrb", 64'(mem_req_wstrb), 64'h80);
    chk("sb_wdata", mem_req_wdata, 64'h5A00000000000000);
    mem_cycle(64'd0);
    tick();

    // 4: faults
    issue(1'b0, 1'b1, 6'b100000, 3'b000, 64'h80000002, 64'd0);
    chk("mis_resp_valid", 64'(resp_valid), 64'd1);
    chk("mis_err", 64'(resp_err), 64'd1);
    chk("mis_rdata", resp_rdata, 64'd0);
    chk("mis_no_mem", 64'(mem_req_valid), 64'd0);
    tick();
    chk("mis_idle", 64'(req_ready), 64'd1);
    issue(1'b1, 1'b1, 6'b000000, 3'b000, 64'h80000000, 64'd0);
    chk("both_resp_valid", 64'(resp_valid), 64'd1);
    chk("both_err", 64'(resp_err), 64'd1);
    chk("both_no_mem", 64'(mem_req_valid), 64'd0);
    tick();
    issue(1'b0, 1'b1, 6'b000100, 3'b000, 64'h80000000, 64'd0);
    chk("rsvd_err", 64'(resp_err), 64'd1);
    chk("rsvd_resp_valid", 64'(resp_valid), 64'd1);
    tick();

    // 5: timeout on the TIMEOUT=4 instance
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("to_ready", 64'(t_req_ready), 64'd1);
    issue(1'b0, 1'b1, 6'b000000, 3'b000, 64'h80000000, 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("to_no_resp", 64'(t_resp_valid), 64'd0);
      mem_req_ready = (i == 0);
      tick();
      mem_req_ready = 1'b0;
    end
    chk("to_resp_valid", 64'(t_resp_valid), 64'd1);
    chk("to_err", 64'(t_resp_err), 64'd1);
    chk("to_no_mem", 64'(t_mem_req_valid), 64'd0);
    tick();
    chk("to_ready_after", 64'(t_req_ready), 64'd1);
    chk("to_pulse", 64'(t_resp_valid), 64'd0);

    // 6: main instance is parked in WAIT; reset it and feed a stale response
    chk("wait_busy", 64'(req_ready), 64'd0);
    rst = 1'b1;
    tick();
    chk("rst2_req_ready", 64'(req_ready), 64'd0);
    chk("rst2_rdata", resp_rdata, 64'd0);
    rst = 1'b0;
    #1;
    chk("rst2_ready_after", 64'(req_ready), 64'd1);
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'hDEADBEEFDEADBEEF;
    tick();
    mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    chk("stale_no_resp", 64'(resp_valid), 64'd0);
    chk("stale_ready", 64'(req_ready), 64'd1);
    tick();
    chk("stale_no_resp2", 64'(resp_valid), 64'd0);
    issue(1'b1, 1'b0, 6'b000000, 3'b000, 64'h80000010, 64'h0123456789ABCDEF);
    chk("sd_addr", mem_req_addr, 64'h80000010);
    chk("sd_wstrb", 64'(mem_req_wstrb), 64'hFF);
    chk("sd_wdata", mem_req_wdata, 64'h0123456789ABCDEF);
    mem_cycle(64'd0);
    chk("sd_resp_valid", 64'(resp_valid), 64'd1);
    chk("sd_err", 64'(resp_err), 64'd0);
    chk("sd_rdata", resp_rdata, 64'd0);
    tick();
    chk("sd_idle", 64'(req_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
